// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch sequencer.
//
// Walks a five-state cycle: it fetches the word at pc_in, holds it for the decoder,
// then steps the PC stage. On a taken branch the PC stage is first loaded and then
// stepped, so a load value of T leaves the PC at T.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   pc_in      current PC from the PC stage
//   ipc        PC increment strobe (one cycle, ADV only)
//   epc        PC load strobe (one cycle, BRLD only)
//   pc_data    PC load value (branch target in BRLD, otherwise 0)
//   mem_req    instruction memory read request
//   mem_addr   instruction memory read address (pc_in while requesting)
//   mem_ack    memory read done; mem_rdata valid in the same cycle
//   mem_rdata  instruction word from memory
//   ir_out     latched instruction word
//   ir_pc      address that ir_out was fetched from
//   ir_valid   ir_out / ir_pc valid for the decoder
//   ir_ready   decoder accepts ir_out this cycle
//   br_req     taken branch, qualified by ir_ready in HOLD
//   br_target  branch destination, sampled with br_req
module instr_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_in,
  output logic        ipc,
  output logic        epc,
  output logic [15:0] pc_data,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ir_out,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        br_req,
  input  logic [15:0] br_target
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StHold,
    StAdv,
    StBrld
  } state_e;

  state_e      state_q;
  logic        armed_q;   // IDLE has seen one full clock cycle after reset release
  logic [15:0] target_q;  // branch target latched in HOLD

  // All state and strobes are registered; each strobe is set on entry to the state
  // that owns it and cleared on exit, so it is high exactly while in that state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      armed_q  <= 1'b0;
      target_q <= 16'h0000;
      ir_out   <= 16'h0000;
      ir_pc    <= 16'h0000;
      ipc      <= 1'b0;
      epc      <= 1'b0;
      mem_req  <= 1'b0;
      ir_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // The first edge after release only arms; the second starts fetching.
          if (armed_q) begin
            state_q <= StReq;
            mem_req <= 1'b1;
          end else begin
            armed_q <= 1'b1;
          end
        end
        StReq: begin
          if (mem_ack) begin
            ir_out   <= mem_rdata;
            ir_pc    <= pc_in;
            mem_req  <= 1'b0;
            ir_valid <= 1'b1;
            state_q  <= StHold;
          end
        end
        StHold: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            if (br_req) begin
              target_q <= br_target;
              epc      <= 1'b1;
              state_q  <= StBrld;
            end else begin
              ipc     <= 1'b1;
              state_q <= StAdv;
            end
          end
        end
        StBrld: begin
          // PC stage now holds target-1; the following increment lands on target.
          epc     <= 1'b0;
          ipc     <= 1'b1;
          state_q <= StAdv;
        end
        StAdv: begin
          ipc     <= 1'b0;
          mem_req <= 1'b1;
          state_q <= StReq;
        end
        default: begin
          state_q  <= StIdle;
          ipc      <= 1'b0;
          epc      <= 1'b0;
          mem_req  <= 1'b0;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

  // pc_in only settles after the ADV edge, so the address tracks it combinationally.
  assign mem_addr = mem_req ? pc_in : 16'h0000;
  assign pc_data  = (state_q == StBrld) ? target_q : 16'h0000;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc_in;
  logic        ipc;
  logic        epc;
  logic [15:0] pc_data;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] ir_out;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        br_req = 1'b0;
  logic [15:0] br_target = 16'h0000;

  int checks = 0;
  int errors = 0;

  // PC stage model: epc stores pc_data-1, ipc increments.
  logic [15:0] pc_q = 16'h0000;
  assign pc_in = pc_q;
  always @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= 16'h0000;
    else if (ipc) pc_q <= pc_q + 16'd1;
    else if (epc) pc_q <= pc_data - 16'd1;
  end

  instr_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .ipc       (ipc),
    .epc       (epc),
    .pc_data   (pc_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_out    (ir_out),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .br_req    (br_req),
    .br_target (br_target)
  );

  always #5 clk = ~clk;

  // ipc and epc must never be high together.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (ipc && epc) begin
        errors++;
        $display("FAIL strobe_excl: ipc=%b epc=%b required not both 1", ipc, epc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ipc, epc, mem_req, ir_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 0000", {ipc, epc, mem_req, ir_valid});
    end
    checks++;
    if ({ir_out, ir_pc, pc_data, mem_addr} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {ir_out, ir_pc, pc_data, mem_addr});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge: mem_req got %b required 0", mem_req);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_second_edge: mem_req=%b addr=%h required 1/0000", mem_req, mem_addr);
    end
  endtask

  task automatic test_linear();
    logic [15:0] words [3] = '{16'h1111, 16'h2222, 16'h3333};
    ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'(i) || ipc !== 1'b0) begin
        errors++;
        $display("FAIL linear_req%0d: req=%b addr=%h ipc=%b required 1/%h/0",
                 i, mem_req, mem_addr, ipc, 16'(i));
      end
      mem_ack = 1'b1;
      mem_rdata = words[i];
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (ir_valid !== 1'b1 || ir_out !== words[i] || ir_pc !== 16'(i)) begin
        errors++;
        $display("FAIL linear_hold%0d: valid=%b ir=%h pc=%h required 1/%h/%h",
                 i, ir_valid, ir_out, ir_pc, words[i], 16'(i));
      end
      @(negedge clk);
      checks++;
      if (ipc !== 1'b1 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL linear_adv%0d: ipc=%b req=%b required 1/0", i, ipc, mem_req);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mem_stall();
    ir_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0003 || ir_valid !== 1'b0 || ipc !== 1'b0) begin
        errors++;
        $display("FAIL mem_stall%0d: req=%b addr=%h valid=%b ipc=%b required 1/0003/0/0",
                 i, mem_req, mem_addr, ir_valid, ipc);
      end
      @(negedge clk);
    end
    mem_ack = 1'b1;
    mem_rdata = 16'hABCD;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (ir_valid !== 1'b1 || ir_out !== 16'hABCD || ir_pc !== 16'h0003) begin
      errors++;
      $display("FAIL mem_stall_done: valid=%b ir=%h pc=%h required 1/abcd/0003",
               ir_valid, ir_out, ir_pc);
    end
  endtask

  task automatic test_dec_stall();
    // br_req without ir_ready must be ignored.
    br_req = 1'b1;
    br_target = 16'h0999;
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ir_valid !== 1'b1 || ir_out !== 16'hABCD || ir_pc !== 16'h0003 ||
          ipc !== 1'b0 || epc !== 1'b0) begin
        errors++;
        $display("FAIL dec_stall%0d: valid=%b ir=%h pc=%h ipc=%b epc=%b required 1/abcd/0003/0/0",
                 i, ir_valid, ir_out, ir_pc, ipc, epc);
      end
    end
    mem_ack = 1'b0;
    br_req = 1'b0;
    ir_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ipc !== 1'b1 || epc !== 1'b0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL dec_stall_adv: ipc=%b epc=%b valid=%b required 1/0/0", ipc, epc, ir_valid);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0004) begin
      errors++;
      $display("FAIL dec_stall_next: req=%b addr=%h required 1/0004", mem_req, mem_addr);
    end
  endtask

  task automatic test_branch();
    mem_ack = 1'b1;
    mem_rdata = 16'h4444;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0005) begin
      errors++;
      $display("FAIL branch_pre: req=%b addr=%h required 1/0005", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 16'h5555;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (ir_pc !== 16'h0005 || pc_data !== 16'h0000) begin
      errors++;
      $display("FAIL branch_hold: ir_pc=%h pc_data=%h required 0005/0000", ir_pc, pc_data);
    end
    br_req = 1'b1;
    br_target = 16'h0040;
    @(negedge clk);
    br_req = 1'b0;
    br_target = 16'h1234;
    checks++;
    if (epc !== 1'b1 || ipc !== 1'b0 || pc_data !== 16'h0040) begin
      errors++;
      $display("FAIL branch_brld: epc=%b ipc=%b pc_data=%h required 1/0/0040", epc, ipc, pc_data);
    end
    @(negedge clk);
    checks++;
    if (ipc !== 1'b1 || epc !== 1'b0 || pc_data !== 16'h0000) begin
      errors++;
      $display("FAIL branch_adv: ipc=%b epc=%b pc_data=%h required 1/0/0000", ipc, epc, pc_data);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin
      errors++;
      $display("FAIL branch_fetch: req=%b addr=%h required 1/0040", mem_req, mem_addr);
    end
  endtask

  task automatic test_branch_zero();
    mem_ack = 1'b1;
    mem_rdata = 16'h4040;
    @(negedge clk);
    mem_ack = 1'b0;
    br_req = 1'b1;
    br_target = 16'h0000;
    @(negedge clk);
    br_req = 1'b0;
    checks++;
    if (epc !== 1'b1 || pc_data !== 16'h0000) begin
      errors++;
      $display("FAIL brzero_brld: epc=%b pc_data=%h required 1/0000", epc, pc_data);
    end
    @(negedge clk);
    checks++;
    if (pc_in !== 16'hFFFF || ipc !== 1'b1) begin
      errors++;
      $display("FAIL brzero_adv: pc_in=%h ipc=%b required ffff/1", pc_in, ipc);
    end
    @(negedge clk);
    checks++;
    if (pc_in !== 16'h0000 || mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL brzero_fetch: pc_in=%h req=%b addr=%h required 0000/1/0000",
               pc_in, mem_req, mem_addr);
    end
  endtask

  task automatic test_reset_mid_req();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ipc, epc, mem_req, ir_valid} !== 4'b0000 || {ir_out, ir_pc, mem_addr} !== 48'h0) begin
      errors++;
      $display("FAIL rst_req_async: strobes=%b ir=%h pc=%h addr=%h required 0",
               {ipc, epc, mem_req, ir_valid}, ir_out, ir_pc, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_held: mem_req=%b required 0", mem_req);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_edge1: mem_req=%b required 0", mem_req);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL rst_req_restart: req=%b addr=%h required 1/0000", mem_req, mem_addr);
    end
  endtask

  task automatic test_reset_mid_brld();
    mem_ack = 1'b1;
    mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (ir_out !== 16'h7777) begin
      errors++;
      $display("FAIL rst_brld_fetch: ir=%h required 7777", ir_out);
    end
    br_req = 1'b1;
    br_target = 16'h0077;
    @(negedge clk);
    br_req = 1'b0;
    checks++;
    if (epc !== 1'b1 || pc_data !== 16'h0077) begin
      errors++;
      $display("FAIL rst_brld_pre: epc=%b pc_data=%h required 1/0077", epc, pc_data);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ipc, epc, mem_req, ir_valid} !== 4'b0000 || {ir_out, pc_data} !== 32'h0) begin
      errors++;
      $display("FAIL rst_brld_async: strobes=%b ir=%h pc_data=%h required 0",
               {ipc, epc, mem_req, ir_valid}, ir_out, pc_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ipc !== 1'b0 || epc !== 1'b0 || mem_req !== 1'b0 || pc_in !== 16'h0000) begin
      errors++;
      $display("FAIL rst_brld_edge1: ipc=%b epc=%b req=%b pc_in=%h required 0/0/0/0000",
               ipc, epc, mem_req, pc_in);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || ipc !== 1'b0) begin
      errors++;
      $display("FAIL rst_brld_restart: req=%b addr=%h ipc=%b required 1/0000/0",
               mem_req, mem_addr, ipc);
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_mem_stall();
    test_dec_stall();
    test_branch();
    test_branch_zero();
    test_reset_mid_req();
    test_reset_mid_brld();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 pc_in  input  16  current program counter value from the PC stage.
REQ-005 ipc  output  1  PC increment strobe to the PC stage.
REQ-006 epc  output  1  PC load strobe to the PC stage.
REQ-007 pc_data  output  16  PC load value; the PC stage stores pc_data-1 on epc.
REQ-008 mem_req  output  1  instruction memory read request.
REQ-009 mem_addr  output  16  instruction memory read address.
REQ-010 mem_ack  input  1  memory read done; mem_rdata valid in the same cycle.
REQ-011 mem_rdata  input  16  instruction word from memory.
REQ-012 ir_out  output  16  latched instruction word.
REQ-013 ir_pc  output  16  address from which ir_out was fetched.
REQ-014 ir_valid  output  1  ir_out and ir_pc are valid for the decoder.
REQ-015 ir_ready  input  1  decoder accepts ir_out this cycle.
REQ-016 br_req  input  1  taken branch; sampled only together with ir_ready.
REQ-017 br_target  input  16  branch destination address, sampled with br_req.

Function
REQ-018 States SHALL be IDLE, REQ, HOLD, ADV and BRLD, held in a registered state variable.
REQ-019 IDLE SHALL last exactly one cycle and then go to REQ.
REQ-020 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal pc_in; both SHALL hold stable until mem_ack.
REQ-021 On mem_ack in REQ, the block SHALL latch ir_out<=mem_rdata and ir_pc<=pc_in, then go to HOLD.
REQ-022 In HOLD, ir_valid SHALL be 1 and ir_out and ir_pc SHALL stay constant until ir_ready.
REQ-023 In HOLD with ir_ready=1 and br_req=0, the next state SHALL be ADV.
REQ-024 In HOLD with ir_ready=1 and br_req=1, the block SHALL latch br_target and go to BRLD.
REQ-025 In BRLD, epc SHALL be 1 for exactly one cycle with pc_data equal to the latched target; the next state SHALL be ADV.
REQ-026 In ADV, ipc SHALL be 1 for exactly one cycle; the next state SHALL be REQ.
REQ-027 ipc and epc SHALL be 1 only in ADV and BRLD respectively, and SHALL never be 1 together.
REQ-028 The first fetch after the PC stage has wrapped from 0xFFFF to 0x0000 SHALL be from address 0x0000.
REQ-029 A branch to target 0x0000 SHALL cause the PC stage to load 0xFFFF in BRLD, increment to 0x0000 in ADV, and fetch from 0x0000.
REQ-030 The block SHALL ignore mem_ack outside REQ, ir_ready outside HOLD, and br_req unless ir_ready=1 in HOLD.
REQ-031 The minimum cost per instruction SHALL be 3 cycles (REQ with immediate ack, HOLD with immediate ready, ADV); a taken branch SHALL add 1 cycle for BRLD.
REQ-032 pc_data SHALL be 0 whenever the state is not BRLD.

Reset
REQ-033 While reset=0, the block SHALL force state=IDLE, ir_out=0, ir_pc=0, the latched target=0, and ipc=epc=mem_req=ir_valid=0, regardless of clk.
REQ-034 Reset asserted mid-operation in any state SHALL abort that operation at once, including a pending memory request or strobe; no partial ipc or epc pulse SHALL follow.
REQ-035 After reset is released, the first mem_req SHALL rise on the second rising clk edge, with mem_addr=0x0000.

Verification
REQ-036 Linear fetch, memory returns 0x1111, 0x2222, 0x3333 with immediate ack and ready: ir_pc=0, 1, 2 in that order; one ipc pulse per instruction; a 3-cycle period.
REQ-037 Memory stall, mem_ack held low for 4 cycles in REQ: mem_req and mem_addr stay constant, no ipc pulse, ir_valid stays 0.
REQ-038 Decoder stall, ir_ready held low for 5 cycles: ir_valid=1, and ir_out and ir_pc do not change, with no ipc pulse.
REQ-039 Branch, ir_ready=1 and br_req=1 with br_target=0x0040 at ir_pc=0x0005: epc pulse with pc_data=0x0040, then an ipc pulse, then mem_addr=0x0040.
REQ-040 Branch to 0x0000 and PC wrap: the PC stage reads 0xFFFF then 0x0000, and the next fetch address is 0x0000.
REQ-041 Reset pulse while in REQ and while in BRLD: all outputs go to 0 immediately, and the sequence restarts with a fetch from 0x0000.
